call_stack_ctrl: RTL and testbench

- Call/return sequencer that sits directly upstream of the register file's stack interface. It drives rf_stack_push, rf_stack_pop and rf_stack_pointer.
- On CALL it saves the return PC in a private return-address LIFO, triggers the register-file frame push, and redirects the PC. On RET it presents the frame address, triggers the frame pop, and restores the PC.
- It reports stack overflow and underflow to the control unit.

---
 rtl/stack_ctrl_pkg.sv | 23 ++
 rtl/ret_addr_lifo.sv | 37 +++
 rtl/call_stack_ctrl.sv | 143 ++++++++++++++
 tb/tb_call_stack_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared types and helpers for the call/return sequencer.
// Default widths here must match the register file's PC width.
package stack_ctrl_pkg;

    localparam int CS_PC_WIDTH = 5;
    localparam int CS_DEPTH    = 8;
    localparam int PTR_W       = CS_PC_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CALL_PUSH = 2'd1,
        RET_ADDR  = 2'd2,
        RET_POP   = 2'd3
    } cs_state_t;

    // Increment that wraps modulo 2**width, so the top address wraps to 0.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (pc + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/ret_addr_lifo.sv
// Return-address storage for frames 1..DEPTH; index 0 is never written or read.
// No reset: contents are only meaningful below the current depth.
module ret_addr_lifo #(
    parameter int PC_WIDTH = 5,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PC_WIDTH-1:0] wr_addr,
    input  logic [PC_WIDTH-1:0] wr_data,
    input  logic [PC_WIDTH-1:0] rd_addr,
    output logic [PC_WIDTH-1:0] rd_data
);

    logic [PC_WIDTH-1:0] mem_q [1:DEPTH];

    generate
        for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (wr_addr == PC_WIDTH'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Address decode keeps out-of-range addresses from reading undefined storage.
    always_comb begin
        rd_data = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (rd_addr == PC_WIDTH'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/call_stack_ctrl.sv
// Call/return sequencer driving the register file's frame push/pop interface.
// CALL: IDLE -> CALL_PUSH -> IDLE.  RET: IDLE -> RET_ADDR -> RET_POP -> IDLE.
module call_stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = CS_PC_WIDTH,
    parameter int DEPTH    = CS_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_call,
    input  logic                cs_ret,
    input  logic [PC_WIDTH-1:0] cs_call_target,
    input  logic [PC_WIDTH-1:0] cs_pc_cur,
    input  logic                cs_err_clr,
    output logic                cs_busy,
    output logic                cs_pc_load,
    output logic [PC_WIDTH-1:0] cs_pc_next,
    output logic                cs_overflow,
    output logic                cs_underflow,
    output logic                rf_stack_push,
    output logic                rf_stack_pop,
    output logic [PC_WIDTH-1:0] rf_stack_pointer
);

    localparam logic [PC_WIDTH-1:0] DEPTH_W = PC_WIDTH'(DEPTH);

    cs_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0] depth_q, depth_d;
    logic [PC_WIDTH-1:0] target_q, target_d;
    logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                idle;
    logic                call_ok, call_ovf, ret_ok, ret_unf;
    logic [PC_WIDTH-1:0] wr_addr, wr_data, rd_data;

    assign idle     = (state_q == IDLE);
    // CALL has priority: a simultaneous RET is dropped even when the CALL overflows.
    assign call_ok  = idle && cs_call && (depth_q < DEPTH_W);
    assign call_ovf = idle && cs_call && (depth_q >= DEPTH_W);
    assign ret_ok   = idle && !cs_call && cs_ret && (depth_q != '0);
    assign ret_unf  = idle && !cs_call && cs_ret && (depth_q == '0);

    assign wr_addr  = depth_q + PC_WIDTH'(1);
    assign wr_data  = PC_WIDTH'(pc_inc(32'(cs_pc_cur), int'(PC_WIDTH)));

    ret_addr_lifo #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (DEPTH)
    ) u_ret_addr_lifo (
        .clk     (clk),
        .we      (call_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (depth_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (call_ok) begin
                    state_d = CALL_PUSH;
                end else if (ret_ok) begin
                    state_d = RET_ADDR;
                end
            end
            CALL_PUSH: state_d = IDLE;
            RET_ADDR:  state_d = RET_POP;
            RET_POP:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_busy       = 1'b1;
        cs_pc_load    = 1'b0;
        rf_stack_push = 1'b0;
        rf_stack_pop  = 1'b0;
        pc_next_d     = pc_next_q;
        case (state_q)
            IDLE: cs_busy = 1'b0;
            CALL_PUSH: begin
                rf_stack_push = 1'b1;
                cs_pc_load    = 1'b1;
                pc_next_d     = target_q;
            end
            RET_POP: begin
                rf_stack_pop = 1'b1;
                cs_pc_load   = 1'b1;
                pc_next_d    = rd_data;
            end
            default: ;
        endcase
    end

    assign cs_pc_next       = pc_next_d;
    assign rf_stack_pointer = depth_q;
    assign cs_overflow      = ovf_q;
    assign cs_underflow     = unf_q;

    always_comb begin
        depth_d  = depth_q;
        target_d = target_q;
        if (call_ok) begin
            depth_d  = depth_q + PC_WIDTH'(1);
            target_d = cs_call_target;
        end else if (state_q == RET_POP) begin
            depth_d = depth_q - PC_WIDTH'(1);
        end
        // A new error in the same cycle as a clear keeps the flag set.
        ovf_d = call_ovf | (ovf_q & ~cs_err_clr);
        unf_d = ret_unf  | (unf_q & ~cs_err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q   <= '0;
            target_q  <= '0;
            pc_next_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            depth_q   <= depth_d;
            target_q  <= target_d;
            pc_next_q <= pc_next_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: one task per scenario with inline checks.
module tb_call_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_call = 1'b0;
    logic       cs_ret = 1'b0;
    logic [4:0] cs_call_target = '0;
    logic [4:0] cs_pc_cur = '0;
    logic       cs_err_clr = 1'b0;
    logic       cs_busy, cs_pc_load, cs_overflow, cs_underflow;
    logic       rf_stack_push, rf_stack_pop;
    logic [4:0] cs_pc_next, rf_stack_pointer;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    call_stack_ctrl #(.PC_WIDTH(5), .DEPTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cs_call          (cs_call),
        .cs_ret           (cs_ret),
        .cs_call_target   (cs_call_target),
        .cs_pc_cur        (cs_pc_cur),
        .cs_err_clr       (cs_err_clr),
        .cs_busy          (cs_busy),
        .cs_pc_load       (cs_pc_load),
        .cs_pc_next       (cs_pc_next),
        .cs_overflow      (cs_overflow),
        .cs_underflow     (cs_underflow),
        .rf_stack_push    (rf_stack_push),
        .rf_stack_pop     (rf_stack_pop),
        .rf_stack_pointer (rf_stack_pointer)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status bundle: {busy, load, push, pop, ovf, unf}
    function automatic logic [5:0] flags();
        return {cs_busy, cs_pc_load, rf_stack_push, rf_stack_pop, cs_overflow, cs_underflow};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if (flags() !== 6'b0 || rf_stack_pointer !== 5'd0 || cs_pc_next !== 5'd0)
            $display("FAIL reset_outputs: flags=%b ptr=%0d next=%0d required flags=000000 ptr=0 next=0",
                     flags(), rf_stack_pointer, cs_pc_next);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        $display("reset released: ptr=%0d", rf_stack_pointer);
    endtask

    task automatic test_call_ret();
        cs_call = 1'b1; cs_pc_cur = 5'd5; cs_call_target = 5'd20;
        tick();
        cs_call = 1'b0;
        $display("call pc=5 tgt=20: push=%b ptr=%0d next=%0d", rf_stack_push, rf_stack_pointer, cs_pc_next);
        total_cnt++;
        if (flags() !== 6'b111000 || rf_stack_pointer !== 5'd1 || cs_pc_next !== 5'd20)
            $display("FAIL call_push: flags=%b ptr=%0d next=%0d required flags=111000 ptr=1 next=20",
                     flags(), rf_stack_pointer, cs_pc_next);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (flags() !== 6'b000000 || rf_stack_pointer !== 5'd1)
            $display("FAIL call_idle: flags=%b ptr=%0d required flags=000000 ptr=1", flags(), rf_stack_pointer);
        else pass_cnt++;
        cs_ret = 1'b1;
        tick();
        cs_ret = 1'b0;
        total_cnt++;
        if (flags() !== 6'b100000 || rf_stack_pointer !== 5'd1)
            $display("FAIL ret_addr: flags=%b ptr=%0d required flags=100000 ptr=1", flags(), rf_stack_pointer);
        else pass_cnt++;
        tick();
        $display("ret: pop=%b ptr=%0d next=%0d", rf_stack_pop, rf_stack_pointer, cs_pc_next);
        total_cnt++;
        if (flags() !== 6'b110100 || rf_stack_pointer !== 5'd1 || cs_pc_next !== 5'd6)
            $display("FAIL ret_pop: flags=%b ptr=%0d next=%0d required flags=110100 ptr=1 next=6",
                     flags(), rf_stack_pointer, cs_pc_next);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (flags() !== 6'b000000 || rf_stack_pointer !== 5'd0)
            $display("FAIL ret_done: flags=%b ptr=%0d required flags=000000 ptr=0", flags(), rf_stack_pointer);
        else pass_cnt++;
    endtask

    task automatic test_nested_overflow();
        for (int i = 0; i < 8; i++) begin
            cs_call = 1'b1; cs_pc_cur = 5'(i); cs_call_target = 5'(i + 10);
            tick();
            cs_call = 1'b0;
            $display("nested call %0d: push=%b ptr=%0d next=%0d", i, rf_stack_push, rf_stack_pointer, cs_pc_next);
            total_cnt++;
            if (rf_stack_push !== 1'b1 || rf_stack_pointer !== 5'(i + 1) || cs_pc_next !== 5'(i + 10))
                $display("FAIL nested_push_%0d: push=%b ptr=%0d next=%0d required push=1 ptr=%0d next=%0d",
                         i, rf_stack_push, rf_stack_pointer, cs_pc_next, i + 1, i + 10);
            else pass_cnt++;
            tick();
        end
        cs_call = 1'b1; cs_pc_cur = 5'd9; cs_call_target = 5'd30;
        tick();
        cs_call = 1'b0;
        $display("9th call: ovf=%b ptr=%0d busy=%b", cs_overflow, rf_stack_pointer, cs_busy);
        total_cnt++;
        if (flags() !== 6'b000010 || rf_stack_pointer !== 5'd8)
            $display("FAIL overflow: flags=%b ptr=%0d required flags=000010 ptr=8", flags(), rf_stack_pointer);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            cs_ret = 1'b1;
            tick();
            cs_ret = 1'b0;
            tick();
            $display("nested ret %0d: pop=%b ptr=%0d next=%0d", k, rf_stack_pop, rf_stack_pointer, cs_pc_next);
            total_cnt++;
            if (rf_stack_pop !== 1'b1 || rf_stack_pointer !== 5'(8 - k) || cs_pc_next !== 5'(8 - k))
                $display("FAIL nested_pop_%0d: pop=%b ptr=%0d next=%0d required pop=1 ptr=%0d next=%0d",
                         k, rf_stack_pop, rf_stack_pointer, cs_pc_next, 8 - k, 8 - k);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (rf_stack_pointer !== 5'd0 || cs_overflow !== 1'b1)
            $display("FAIL nested_end: ptr=%0d ovf=%b required ptr=0 ovf=1", rf_stack_pointer, cs_overflow);
        else pass_cnt++;
        cs_err_clr = 1'b1;
        tick();
        cs_err_clr = 1'b0;
        total_cnt++;
        if (cs_overflow !== 1'b0)
            $display("FAIL ovf_clear: ovf=%b required 0", cs_overflow);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        cs_ret = 1'b1;
        tick();
        cs_ret = 1'b0;
        $display("ret at depth 0: unf=%b busy=%b", cs_underflow, cs_busy);
        total_cnt++;
        if (flags() !== 6'b000001 || rf_stack_pointer !== 5'd0)
            $display("FAIL underflow: flags=%b ptr=%0d required flags=000001 ptr=0", flags(), rf_stack_pointer);
        else pass_cnt++;
        cs_ret = 1'b1; cs_err_clr = 1'b1;
        tick();
        cs_ret = 1'b0;
        total_cnt++;
        if (cs_underflow !== 1'b1)
            $display("FAIL unf_err_wins: unf=%b required 1", cs_underflow);
        else pass_cnt++;
        tick();
        cs_err_clr = 1'b0;
        total_cnt++;
        if (cs_underflow !== 1'b0)
            $display("FAIL unf_clear: unf=%b required 0", cs_underflow);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        cs_call = 1'b1; cs_pc_cur = 5'd31; cs_call_target = 5'd3;
        tick();
        cs_call = 1'b0;
        tick();
        cs_ret = 1'b1;
        tick();
        cs_ret = 1'b0;
        tick();
        $display("wrap ret: pop=%b next=%0d", rf_stack_pop, cs_pc_next);
        total_cnt++;
        if (rf_stack_pop !== 1'b1 || cs_pc_next !== 5'd0)
            $display("FAIL wrap_ret: pop=%b next=%0d required pop=1 next=0", rf_stack_pop, cs_pc_next);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 2; i++) begin
            cs_call = 1'b1; cs_pc_cur = 5'(i); cs_call_target = 5'(i + 20);
            tick();
            cs_call = 1'b0;
            tick();
        end
        cs_call = 1'b1; cs_ret = 1'b1; cs_pc_cur = 5'd10; cs_call_target = 5'd12;
        tick();
        cs_call = 1'b0; cs_ret = 1'b0;
        $display("call+ret at D=2: push=%b pop=%b ptr=%0d", rf_stack_push, rf_stack_pop, rf_stack_pointer);
        total_cnt++;
        if (flags() !== 6'b111000 || rf_stack_pointer !== 5'd3 || cs_pc_next !== 5'd12)
            $display("FAIL call_wins: flags=%b ptr=%0d next=%0d required flags=111000 ptr=3 next=12",
                     flags(), rf_stack_pointer, cs_pc_next);
        else pass_cnt++;
        tick();
        cs_ret = 1'b1;
        tick();
        cs_ret = 1'b0;
        cs_call = 1'b1; cs_pc_cur = 5'd25; cs_call_target = 5'd26;
        tick();
        cs_call = 1'b0;
        $display("ret with ignored call: pop=%b push=%b ptr=%0d next=%0d",
                 rf_stack_pop, rf_stack_push, rf_stack_pointer, cs_pc_next);
        total_cnt++;
        if (flags() !== 6'b110100 || rf_stack_pointer !== 5'd3 || cs_pc_next !== 5'd11)
            $display("FAIL busy_ignore: flags=%b ptr=%0d next=%0d required flags=110100 ptr=3 next=11",
                     flags(), rf_stack_pointer, cs_pc_next);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (flags() !== 6'b000000 || rf_stack_pointer !== 5'd2)
            $display("FAIL busy_ignore_after: flags=%b ptr=%0d required flags=000000 ptr=2",
                     flags(), rf_stack_pointer);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_call();
        cs_call = 1'b1; cs_pc_cur = 5'd4; cs_call_target = 5'd17;
        tick();
        cs_call = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("async reset in CALL_PUSH: push=%b ptr=%0d", rf_stack_push, rf_stack_pointer);
        total_cnt++;
        if (flags() !== 6'b000000 || rf_stack_pointer !== 5'd0 || cs_pc_next !== 5'd0)
            $display("FAIL reset_mid: flags=%b ptr=%0d next=%0d required flags=000000 ptr=0 next=0",
                     flags(), rf_stack_pointer, cs_pc_next);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (flags() !== 6'b000000 || rf_stack_pointer !== 5'd0)
            $display("FAIL reset_mid_after: flags=%b ptr=%0d required flags=000000 ptr=0",
                     flags(), rf_stack_pointer);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_nested_overflow();
        test_underflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid_call();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
